// File: rtl/park_gate_ctrl.sv
// Car-park barrier controller: arbitrates entry/exit requests, opens one barrier at a time,
// and keeps a saturating occupancy count updated only on confirmed passes.
module park_gate_ctrl #(
  parameter int unsigned Capacity = 12,
  parameter int unsigned CntW     = 4,
  parameter int unsigned Timeout  = 16,
  parameter int unsigned TmrW     = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            entry_req_i,
  input  logic            exit_req_i,
  input  logic            entry_pass_i,
  input  logic            exit_pass_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            entry_open_o,
  output logic            exit_open_o,
  output logic            entry_denied_o
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StEntryOpen = 2'd1,
    StExitOpen  = 2'd2
  } state_e;

  localparam logic [CntW-1:0] CapCnt  = CntW'(Capacity);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(Timeout - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              entry_prev_q, exit_prev_q;
  logic              denied_q, denied_d;

  logic entry_rise, exit_rise;
  logic can_exit, can_enter, is_full;

  assign entry_rise = entry_pass_i & ~entry_prev_q;
  assign exit_rise  = exit_pass_i & ~exit_prev_q;
  assign is_full    = (count_q == CapCnt);
  assign can_exit   = exit_req_i & (count_q != '0);
  assign can_enter  = entry_req_i & ~is_full;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    // Refusal only when the request is actually being arbitrated and no exit wins instead.
    denied_d = (state_q == StIdle) & entry_req_i & is_full & ~can_exit;

    unique case (state_q)
      StIdle: begin
        if (can_exit) begin
          state_d = StExitOpen;
          timer_d = '0;
        end else if (can_enter) begin
          state_d = StEntryOpen;
          timer_d = '0;
        end
      end
      StEntryOpen: begin
        if (entry_rise) begin
          count_d = count_q + CntW'(1);
          state_d = StIdle;
        end else if (timer_q == TmrLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StExitOpen: begin
        if (exit_rise) begin
          count_d = count_q - CntW'(1);
          state_d = StIdle;
        end else if (timer_q == TmrLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      timer_q      <= '0;
      entry_prev_q <= 1'b0;
      exit_prev_q  <= 1'b0;
      denied_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      entry_prev_q <= entry_pass_i;
      exit_prev_q  <= exit_pass_i;
      denied_q     <= denied_d;
    end
  end

  assign count_o        = count_q;
  assign full_o         = is_full;
  assign entry_open_o   = (state_q == StEntryOpen);
  assign exit_open_o    = (state_q == StExitOpen);
  assign entry_denied_o = denied_q;

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Directed testbench for park_gate_ctrl: reset, entry, fill/deny, arbitration, timeout,
// back-to-back openings and reset during an open barrier.
module tb_park_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       entry_req, exit_req, entry_pass, exit_pass;
  logic [3:0] count;
  logic       full, entry_open, exit_open, entry_denied;

  int vectors    = 0;
  int miscompares = 0;

  park_gate_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .entry_req_i    (entry_req),
    .exit_req_i     (exit_req),
    .entry_pass_i   (entry_pass),
    .exit_pass_i    (exit_pass),
    .count_o        (count),
    .full_o         (full),
    .entry_open_o   (entry_open),
    .exit_open_o    (exit_open),
    .entry_denied_o (entry_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one full entry (request, open, pass) taking three edges.
  task automatic do_entry();
    entry_req = 1'b1;
    step();
    entry_req  = 1'b0;
    entry_pass = 1'b1;
    step();
    entry_pass = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (count !== 4'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", count);
    end
    vectors++;
    if (full !== 1'b0) begin
      miscompares++; $display("FAIL reset_full: got %b want 0", full);
    end
    vectors++;
    if (entry_open !== 1'b0) begin
      miscompares++; $display("FAIL reset_entry_open: got %b want 0", entry_open);
    end
    vectors++;
    if (exit_open !== 1'b0) begin
      miscompares++; $display("FAIL reset_exit_open: got %b want 0", exit_open);
    end
    vectors++;
    if (entry_denied !== 1'b0) begin
      miscompares++; $display("FAIL reset_denied: got %b want 0", entry_denied);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_entry();
    entry_req = 1'b1;
    step();
    vectors++;
    if (entry_open !== 1'b1) begin
      miscompares++; $display("FAIL entry_open_latency: got %b want 1", entry_open);
    end
    entry_req = 1'b0;
    step();
    step();
    vectors++;
    if (count !== 4'd0) begin
      miscompares++; $display("FAIL entry_count_before_pass: got %0d want 0", count);
    end
    entry_pass = 1'b1;
    step();
    vectors++;
    if (count !== 4'd1) begin
      miscompares++; $display("FAIL entry_count_after_pass: got %0d want 1", count);
    end
    vectors++;
    if (entry_open !== 1'b0) begin
      miscompares++; $display("FAIL entry_closed_after_pass: got %b want 0", entry_open);
    end
    // Sensor held high must not count again.
    step();
    entry_pass = 1'b0;
    step();
    vectors++;
    if (count !== 4'd1) begin
      miscompares++; $display("FAIL entry_held_sensor: got %0d want 1", count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 11; i++) do_entry();
    vectors++;
    if (count !== 4'd12) begin
      miscompares++; $display("FAIL fill_count: got %0d want 12", count);
    end
    vectors++;
    if (full !== 1'b1) begin
      miscompares++; $display("FAIL fill_full: got %b want 1", full);
    end
    entry_req = 1'b1;
    step();
    vectors++;
    if (entry_denied !== 1'b1) begin
      miscompares++; $display("FAIL fill_denied: got %b want 1", entry_denied);
    end
    vectors++;
    if (entry_open !== 1'b0) begin
      miscompares++; $display("FAIL fill_no_open: got %b want 0", entry_open);
    end
    step();
    vectors++;
    if (entry_denied !== 1'b1) begin
      miscompares++; $display("FAIL fill_denied_held: got %b want 1", entry_denied);
    end
    // A waiting exit takes priority, so the refusal drops.
    exit_req = 1'b1;
    step();
    vectors++;
    if (entry_denied !== 1'b0 || exit_open !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_exit_priority: got denied=%b exit_open=%b want denied=0 exit_open=1",
               entry_denied, exit_open);
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_pass = 1'b1;
    step();
    exit_pass = 1'b0;
    step();
    vectors++;
    if (count !== 4'd11 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_after_exit: got count=%0d full=%b want count=11 full=0", count, full);
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) do_entry();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    step();
    vectors++;
    if (exit_open !== 1'b1 || entry_open !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_exit_first: got exit=%b entry=%b want exit=1 entry=0",
               exit_open, entry_open);
    end
    exit_req  = 1'b0;
    exit_pass = 1'b1;
    step();
    vectors++;
    if (count !== 4'd4 || exit_open !== 1'b0 || entry_open !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_exit_pass: got count=%0d exit=%b entry=%b want 4 0 0",
               count, exit_open, entry_open);
    end
    exit_pass = 1'b0;
    step();
    vectors++;
    if (entry_open !== 1'b1) begin
      miscompares++; $display("FAIL simul_entry_second: got %b want 1", entry_open);
    end
    entry_req  = 1'b0;
    entry_pass = 1'b1;
    step();
    entry_pass = 1'b0;
    vectors++;
    if (count !== 4'd5) begin
      miscompares++; $display("FAIL simul_entry_pass: got %0d want 5", count);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (entry_open !== 1'b1) break;
      n++;
      exit_pass = (i == 3); // pass on the closed side must be ignored
      step();
    end
    exit_pass = 1'b0;
    vectors++;
    if (n !== 16) begin
      miscompares++; $display("FAIL timeout_open_cycles: got %0d want 16", n);
    end
    vectors++;
    if (count !== 4'd5) begin
      miscompares++; $display("FAIL timeout_count: got %0d want 5", count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    entry_req = 1'b1;
    step();
    entry_pass = 1'b1;
    step();
    vectors++;
    if (entry_open !== 1'b0 || count !== 4'd6) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: got open=%b count=%0d want open=0 count=6", entry_open, count);
    end
    entry_pass = 1'b0;
    step();
    vectors++;
    if (entry_open !== 1'b1) begin
      miscompares++; $display("FAIL b2b_reopen: got %b want 1", entry_open);
    end
    entry_req  = 1'b0;
    entry_pass = 1'b1;
    step();
    entry_pass = 1'b0;
    step();
    vectors++;
    if (count !== 4'd7) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 7", count);
    end
  endtask

  task automatic test_reset_midop();
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    vectors++;
    if (exit_open !== 1'b1 || count !== 4'd7) begin
      miscompares++;
      $display("FAIL midop_setup: got exit=%b count=%0d want exit=1 count=7", exit_open, count);
    end
    rst       = 1'b1;
    exit_pass = 1'b1;
    step();
    vectors++;
    if (exit_open !== 1'b0 || count !== 4'd0) begin
      miscompares++;
      $display("FAIL midop_reset: got exit=%b count=%0d want exit=0 count=0", exit_open, count);
    end
    rst = 1'b0;
    step();
    exit_pass = 1'b0;
    step();
    vectors++;
    if (count !== 4'd0) begin
      miscompares++; $display("FAIL midop_stray_pass: got %0d want 0", count);
    end
    exit_req = 1'b1;
    step();
    vectors++;
    if (exit_open !== 1'b0) begin
      miscompares++; $display("FAIL exit_when_empty: got %b want 0", exit_open);
    end
    exit_req   = 1'b0;
    entry_pass = 1'b1; // edge while idle must not count
    step();
    entry_pass = 1'b0;
    step();
    vectors++;
    if (count !== 4'd0) begin
      miscompares++; $display("FAIL idle_pass_ignored: got %0d want 0", count);
    end
  endtask

  initial begin
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    entry_pass = 1'b0;
    exit_pass  = 1'b0;
    test_reset();
    test_entry();
    test_fill();
    test_simultaneous();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
